// File: rtl/seg7_pkg.sv
// Shared types and active-low glyph constants for the seven-segment display path.
// Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;

  localparam seg7_t SEG_0 = 7'b1000000;
  localparam seg7_t SEG_1 = 7'b1111001;
  localparam seg7_t SEG_2 = 7'b0100100;
  localparam seg7_t SEG_3 = 7'b0110000;
  localparam seg7_t SEG_4 = 7'b0011001;
  localparam seg7_t SEG_5 = 7'b0010010;
  localparam seg7_t SEG_6 = 7'b0000010;
  localparam seg7_t SEG_7 = 7'b1111000;
  localparam seg7_t SEG_8 = 7'b0000000;
  localparam seg7_t SEG_9 = 7'b0010000;
  localparam seg7_t SEG_A = 7'b0001000;
  localparam seg7_t SEG_B = 7'b0000011;
  localparam seg7_t SEG_C = 7'b1000110;
  localparam seg7_t SEG_D = 7'b0100001;
  localparam seg7_t SEG_E = 7'b0000110;
  localparam seg7_t SEG_F = 7'b0001110;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg7_t      seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nib_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with an optional scrolling window.
// Optional leading-zero blanking in static mode: define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int MSG_DIGITS  = 8,
  parameter int REFRESH_DIV = 50000,
  parameter int SCROLL_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*MSG_DIGITS-1:0] msg_in,
  input  logic                    mode,
  output logic [6:0]              seg_L,
  output logic [NUM_DIGITS-1:0]   anode_L,
  output logic                    scroll_wrap
);

  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SCR_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int OFF_W = (MSG_DIGITS > 1) ? $clog2(MSG_DIGITS) : 1;

  logic [4*MSG_DIGITS-1:0] msg_q, msg_d;
  logic [REF_W-1:0]        ref_cnt_q, ref_cnt_d;
  logic [DIG_W-1:0]        digit_q, digit_d;
  logic [OFF_W-1:0]        offset_q, offset_d;
  logic [SCR_W-1:0]        scr_cnt_q, scr_cnt_d;
  seg7_t                   seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic                    wrap_q, wrap_d;

  logic                    ref_wrap;
  logic                    scr_step;
  logic [OFF_W:0]          idx_sum;
  logic [3:0]              nibble;
  seg7_t                   dec_seg;
  logic                    blank;

  seg7_hex_decode u_dec (
    .nib_i (nibble),
    .seg_o (dec_seg)
  );

  // Window position of the active digit; offset and digit are both < MSG_DIGITS.
  always_comb begin
    idx_sum = {1'b0, offset_q} + (OFF_W+1)'(digit_q);
    if (idx_sum >= (OFF_W+1)'(MSG_DIGITS)) idx_sum = idx_sum - (OFF_W+1)'(MSG_DIGITS);
    nibble = msg_q[{idx_sum, 2'b00} +: 4];
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic lead_zero;

  always_comb begin
    lead_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(digit_q) &&
          msg_q[((int'(offset_q) + k) % MSG_DIGITS)*4 +: 4] != 4'h0) lead_zero = 1'b0;
    end
  end

  assign blank = !mode && (digit_q != '0) && lead_zero;
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    ref_wrap  = (ref_cnt_q == REF_W'(REFRESH_DIV-1));
    ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + 1'b1;
    digit_d   = digit_q;
    if (ref_wrap) digit_d = (digit_q == DIG_W'(NUM_DIGITS-1)) ? '0 : digit_q + 1'b1;

    scr_step  = mode && (scr_cnt_q == SCR_W'(SCROLL_DIV-1));
    msg_d     = msg_q;
    offset_d  = offset_q;
    scr_cnt_d = scr_cnt_q;
    wrap_d    = 1'b0;
    // Load outranks a coincident scroll step, so no wrap pulse on that edge.
    if (load) begin
      msg_d     = msg_in;
      offset_d  = '0;
      scr_cnt_d = '0;
    end else if (!mode) begin
      offset_d  = '0;
      scr_cnt_d = '0;
    end else if (scr_step) begin
      scr_cnt_d = '0;
      wrap_d    = (offset_q == OFF_W'(MSG_DIGITS-1));
      offset_d  = wrap_d ? '0 : offset_q + 1'b1;
    end else begin
      scr_cnt_d = scr_cnt_q + 1'b1;
    end

    seg_d   = blank ? SEG_BLANK : dec_seg;
    anode_d = (ref_cnt_q == '0) ? '1 : ~(NUM_DIGITS'(1) << digit_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg_q     <= '0;
      ref_cnt_q <= '0;
      digit_q   <= '0;
      offset_q  <= '0;
      scr_cnt_q <= '0;
      seg_q     <= SEG_BLANK;
      anode_q   <= '1;
      wrap_q    <= 1'b0;
    end else begin
      msg_q     <= msg_d;
      ref_cnt_q <= ref_cnt_d;
      digit_q   <= digit_d;
      offset_q  <= offset_d;
      scr_cnt_q <= scr_cnt_d;
      seg_q     <= seg_d;
      anode_q   <= anode_d;
      wrap_q    <= wrap_d;
    end
  end

  assign seg_L       = seg_q;
  assign anode_L     = anode_q;
  assign scroll_wrap = wrap_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: glyph vector table plus scan/scroll/reset sequences.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int MD = 8;
  localparam int RD = 4;
  localparam int SD = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] msg_in = '0;
  logic [6:0]  seg_L;
  logic [3:0]  anode_L;
  logic        scroll_wrap;

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  logic [6:0] glyph [16];

  typedef struct {
    logic [31:0] msg;
    int          dig;
    logic [6:0]  seg;
  } vec_t;
  vec_t vecs [20];

  seg7_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .MSG_DIGITS  (MD),
    .REFRESH_DIV (RD),
    .SCROLL_DIV  (SD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .msg_in      (msg_in),
    .mode        (mode),
    .seg_L       (seg_L),
    .anode_L     (anode_L),
    .scroll_wrap (scroll_wrap)
  );

  // Clock and reset-relative edge counter.
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) n <= 0;
    else      n <= n + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic do_load(input logic [31:0] msg, input logic md, output int base);
    msg_in = msg;
    mode   = md;
    load   = 1'b1;
    tick();
    base   = n;
    load   = 1'b0;
  endtask

  function automatic logic [6:0] model_seg(input logic [31:0] msg, input logic md,
                                           input int off, input int d);
    logic [3:0] nib;
    nib = msg[((off + d) % MD)*4 +: 4];
    model_seg = glyph[nib];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (!md && d > 0) begin
      bit z;
      z = 1'b1;
      for (int k = d; k < ND; k++) if (msg[((off + k) % MD)*4 +: 4] != 4'h0) z = 1'b0;
      if (z) model_seg = 7'h7F;
    end
`endif
  endfunction

  // Outputs after edge m reflect the state left by edge m-1.
  task automatic check_window(input logic [31:0] msg, input logic md, input int base,
                              input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      int m, off, d;
      logic [3:0] ea;
      tick();
      m   = n;
      off = md ? ((m - 1 - base) / SD) % MD : 0;
      d   = ((m - 1) / RD) % ND;
      ea  = ((m - 1) % RD == 0) ? 4'hF : ~(4'b0001 << d);
      check("anode", anode_L, ea);
      check("seg", seg_L, model_seg(msg, md, off, d));
      check("wrap", scroll_wrap, (md && (m - base) > 0 && (m - base) % (SD*MD) == 0));
    end
  endtask

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b, b2, got;

    glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
    glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010; glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000;
    glyph[8]  = 7'b0000000; glyph[9]  = 7'b0010000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
    glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110; glyph[15] = 7'b0001110;

    vecs[0]  = '{32'h0000_1A90, 0, 7'b1000000};
    vecs[1]  = '{32'h0000_1A90, 1, 7'b0010000};
    vecs[2]  = '{32'h0000_1A90, 2, 7'b0001000};
    vecs[3]  = '{32'h0000_1A90, 3, 7'b1111001};
    vecs[4]  = '{32'h7654_3210, 0, 7'b1000000};
    vecs[5]  = '{32'h7654_3210, 1, 7'b1111001};
    vecs[6]  = '{32'h7654_3210, 2, 7'b0100100};
    vecs[7]  = '{32'h7654_3210, 3, 7'b0110000};
    vecs[8]  = '{32'h0000_7654, 0, 7'b0011001};
    vecs[9]  = '{32'h0000_7654, 1, 7'b0010010};
    vecs[10] = '{32'h0000_7654, 2, 7'b0000010};
    vecs[11] = '{32'h0000_7654, 3, 7'b1111000};
    vecs[12] = '{32'h0000_BA98, 0, 7'b0000000};
    vecs[13] = '{32'h0000_BA98, 1, 7'b0010000};
    vecs[14] = '{32'h0000_BA98, 2, 7'b0001000};
    vecs[15] = '{32'h0000_BA98, 3, 7'b0000011};
    vecs[16] = '{32'h0000_FEDC, 0, 7'b1000110};
    vecs[17] = '{32'h0000_FEDC, 1, 7'b0100001};
    vecs[18] = '{32'h0000_FEDC, 2, 7'b0000110};
    vecs[19] = '{32'h0000_FEDC, 3, 7'b0001110};

    // Reset held: inputs wiggle, outputs must stay blank.
    for (int i = 0; i < 4; i++) begin
      load   = 1'($urandom_range(0, 1));
      mode   = 1'($urandom_range(0, 1));
      msg_in = $urandom;
      tick();
      check("rst_seg", seg_L, 7'h7F);
      check("rst_anode", anode_L, 4'hF);
      check("rst_wrap", scroll_wrap, 1'b0);
    end
    load = 1'b0; mode = 1'b0; msg_in = '0;
    rst = 1'b1;
    tick();
    check("rel_dead_anode", anode_L, 4'hF);
    tick();
    check("rel_first_anode", anode_L, 4'hE);
    check("rel_first_seg", seg_L, 7'b1000000);

    // Glyph table, static mode.
    for (int i = 0; i < 20; i++) begin
      do_load(vecs[i].msg, 1'b0, b);
      got = 0;
      for (int c = 0; c < 40 && got == 0; c++) begin
        tick();
        if (anode_L == ~(4'b0001 << vecs[i].dig)) got = 1;
      end
      check($sformatf("slot_wait%0d", i), got, 1);
      if (got != 0) check($sformatf("vec%0d", i), seg_L, vecs[i].seg);
    end

    // Static scan cadence.
    do_load(32'h0000_1A90, 1'b0, b);
    check_window(32'h0000_1A90, 1'b0, b, 16);

    // Scroll through a full wrap with one pulse.
    do_load(32'h7654_3210, 1'b1, b);
    check_window(32'h7654_3210, 1'b1, b, 140);

    // Load on the exact edge that would wrap the offset.
    while (n < b + 255) tick();
    do_load(32'h89AB_CDEF, 1'b1, b2);
    check("collide_wrap", scroll_wrap, 1'b0);
    check_window(32'h89AB_CDEF, 1'b1, b2, 86);

    // Async reset mid-cycle with offset at 5.
    #3;
    rst = 1'b0;
    #1;
    check("arst_seg", seg_L, 7'h7F);
    check("arst_anode", anode_L, 4'hF);
    check("arst_wrap", scroll_wrap, 1'b0);
    tick();
    check("arst_hold_anode", anode_L, 4'hF);
    rst = 1'b1;
    tick();
    check("arel_dead_anode", anode_L, 4'hF);
    tick();
    check("arel_first_anode", anode_L, 4'hE);
    check("arel_first_seg", seg_L, 7'b1000000);
    do_load(32'h7654_3210, 1'b1, b);
    check_window(32'h7654_3210, 1'b1, b, 40);

    // Leaving scroll mode clears the offset on the next edge.
    mode = 1'b0;
    tick();
    check_window(32'h7654_3210, 1'b0, 0, 16);

    // Leading-zero cases in static mode; scroll mode never blanks.
    do_load(32'h0000_0005, 1'b0, b);
    check_window(32'h0000_0005, 1'b0, b, 16);
    do_load(32'h0000_0000, 1'b0, b);
    check_window(32'h0000_0000, 1'b0, b, 16);
    do_load(32'h0000_0005, 1'b1, b);
    check_window(32'h0000_0005, 1'b1, b, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
